dtack_generator: RTL

- Bus-cycle terminator that sits directly downstream of the glue logic address decoder.
- Consumes the active-low RAM, ROM, UART and PIT selects and produces a registered, active-low DTACK.
- Inserts a per-region, parameterised number of wait states before asserting DTACK, and holds DTACK until the CPU ends the cycle.
- Replaces the purely combinational RAM/ROM-only DTACK, so slow peripherals (UART, PIT) get correctly timed acknowledges.

---
 rtl/dtack_generator_pkg.sv | 5 +
 rtl/dtack_generator_if.sv | 19 +
 rtl/dtack_generator_ws_counter.sv | 20 ++
 rtl/dtack_generator.sv | 69 ++++++
 4 files changed

// File: rtl/dtack_generator_pkg.sv
// dtack_generator_pkg: FSM state and region encodings shared by the DTACK generator files.
package dtack_generator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
  typedef enum logic [1:0] {REG_RAM = 2'd0, REG_ROM = 2'd1, REG_UART = 2'd2, REG_PIT = 2'd3} region_t;
endpackage

// File: rtl/dtack_generator_if.sv
// dtack_generator_if: decoder selects, address strobe and DTACK status bundle.
// DTACK_PERIPH_ACK_EN adds the peripheral chip's own DTACK input.
interface dtack_generator_if;
  logic as_n, ram_sel_n, rom_sel_n, uart_sel_n, pit_sel_n;
  logic dtack_n, busy;
  logic [1:0] region;
`ifdef DTACK_PERIPH_ACK_EN
  logic periph_dtack_n;
  modport master (output as_n, ram_sel_n, rom_sel_n, uart_sel_n, pit_sel_n, periph_dtack_n,
                  input dtack_n, busy, region);
  modport slave (input as_n, ram_sel_n, rom_sel_n, uart_sel_n, pit_sel_n, periph_dtack_n,
                 output dtack_n, busy, region);
`else
  modport master (output as_n, ram_sel_n, rom_sel_n, uart_sel_n, pit_sel_n,
                  input dtack_n, busy, region);
  modport slave (input as_n, ram_sel_n, rom_sel_n, uart_sel_n, pit_sel_n,
                 output dtack_n, busy, region);
`endif
endinterface

// File: rtl/dtack_generator_ws_counter.sv
// ws_counter: loadable down counter that saturates at zero, with zero/one flags.
module ws_counter #(
  parameter int WS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            dec_i,
  input  logic [WS_W-1:0] load_val_i,
  output logic            is_zero_o,
  output logic            is_one_o
);
  logic [WS_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign is_zero_o = cnt_q == '0;
  assign is_one_o = cnt_q == WS_W'(1);
endmodule

// File: rtl/dtack_generator.sv
// dtack_generator: registered active-low DTACK after per-region wait states, held until AS ends.
// DTACK_PERIPH_ACK_EN lets a synchronised peripheral DTACK end UART/PIT waits early.
module dtack_generator
  import dtack_generator_pkg::*;
#(
  parameter int WS_W    = 4,
  parameter int RAM_WS  = 0,
  parameter int ROM_WS  = 1,
  parameter int UART_WS = 3,
  parameter int PIT_WS  = 2
) (
  input logic clk,
  input logic rst,
  dtack_generator_if.slave bus
);
  state_t state_q, state_d;
  region_t region_q, region_d, sel_region;
  logic [WS_W-1:0] sel_ws;
  logic active, start, lat_sel_n, cnt_zero, cnt_one, early;
  always_comb begin
    sel_region = !bus.ram_sel_n ? REG_RAM : !bus.rom_sel_n ? REG_ROM : !bus.uart_sel_n ? REG_UART : REG_PIT;
    sel_ws = sel_region == REG_RAM ? WS_W'(RAM_WS) : sel_region == REG_ROM ? WS_W'(ROM_WS) :
             sel_region == REG_UART ? WS_W'(UART_WS) : WS_W'(PIT_WS);
    active = !bus.as_n && !(&{bus.ram_sel_n, bus.rom_sel_n, bus.uart_sel_n, bus.pit_sel_n});
    start = state_q == IDLE && active;
    lat_sel_n = region_q == REG_RAM ? bus.ram_sel_n : region_q == REG_ROM ? bus.rom_sel_n :
                region_q == REG_UART ? bus.uart_sel_n : bus.pit_sel_n;
    region_d = start ? sel_region : region_q;
  end
`ifdef DTACK_PERIPH_ACK_EN
  logic [1:0] psync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) psync_q <= 2'b11;
    else psync_q <= {psync_q[0], bus.periph_dtack_n};
  assign early = !psync_q[1] && (region_q == REG_UART || region_q == REG_PIT);
`else
  assign early = 1'b0;
`endif
  ws_counter #(.WS_W(WS_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start),
    .dec_i      (state_q == WAIT),
    .load_val_i (sel_ws),
    .is_zero_o  (cnt_zero),
    .is_one_o   (cnt_one)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      region_q <= REG_RAM;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
    end
  // abort takes precedence over expiry so a dropped strobe never yields a late DTACK
  always_comb
    case (state_q)
      IDLE:    state_d = !active ? IDLE : sel_ws == '0 ? ACK : WAIT;
      WAIT:    state_d = (bus.as_n || lat_sel_n) ? IDLE : (cnt_one || cnt_zero || early) ? ACK : WAIT;
      ACK:     state_d = bus.as_n ? IDLE : ACK;
      default: state_d = IDLE;
    endcase
  always_comb begin
    bus.dtack_n = state_q != ACK;
    bus.busy    = state_q != IDLE;
    bus.region  = region_q;
  end
endmodule
